// File: rtl/corefifo_rd_ctrl.sv
// Read-side pointer and status controller for an asynchronous FIFO.
// Lives in the read clock domain. It takes the write pointer, already synchronized
// and converted to binary, and from it derives:
//   - the read pointer (binary and gray)
//   - the RAM read address and enable
//   - the fill count and the empty / almost-empty flags
//   - the underflow pulse
//   - read-data-valid, aligned to the RAM read latency
//   - a sticky pointer-consistency error
//
// Handshake: rd_en is a request, not a strobe. It is accepted (ram_re=1) only in a
// cycle where the registered empty flag is low. A refused request (rd_en while empty)
// leaves the pointer untouched and raises underflow on the next edge. rvalid marks
// the RAM output RD_LATENCY cycles after each accepted read. There is no backpressure
// on rvalid.
module corefifo_rd_ctrl #(
    parameter int ADDRWIDTH     = 3,
    parameter int AEMPTY_THRESH = 1,
    parameter int RD_LATENCY    = 1
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic                 rd_en,
    input  logic [ADDRWIDTH:0]   wptr_bin,
    output logic [ADDRWIDTH-1:0] raddr,
    output logic                 ram_re,
    output logic [ADDRWIDTH:0]   rptr_gray,
    output logic [ADDRWIDTH:0]   rdcnt,
    output logic                 empty,
    output logic                 aempty,
    output logic                 underflow,
    output logic                 rvalid,
    output logic                 ptr_err
);

    localparam int PW = ADDRWIDTH + 1;

    // Thresholds widened to 32 bits, so the count compares without truncation.
    localparam logic [31:0] DEPTH_U  = 1 << ADDRWIDTH;
    localparam logic [31:0] THRESH_U = AEMPTY_THRESH;

    logic [PW-1:0]         rptr_bin;
    logic [PW-1:0]         rptr_next;
    logic [PW-1:0]         cnt_next;
    logic [31:0]           cnt_wide;
    logic                  re_acc;
    logic [RD_LATENCY-1:0] rv_pipe;

    // Accept a read only when the registered flag says data is present.
    // Gating with ~empty also keeps an unknown rd_en from moving the pointer
    // while the FIFO is empty.
    always_comb begin
        re_acc    = rd_en & ~empty;
        rptr_next = rptr_bin + {{(PW-1){1'b0}}, re_acc};
        cnt_next  = wptr_bin - rptr_next;
        cnt_wide  = {{(32-PW){1'b0}}, cnt_next};
    end

    assign ram_re = re_acc;
    assign raddr  = rptr_bin[ADDRWIDTH-1:0];
    assign rvalid = rv_pipe[RD_LATENCY-1];

    // Pointer, count and flag registers.
    // Flags come from the post-read count, so a drain of the last word blocks the
    // very next request.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rptr_bin  <= '0;
            rptr_gray <= '0;
            rdcnt     <= '0;
            empty     <= 1'b1;
            aempty    <= 1'b1;
            underflow <= 1'b0;
            ptr_err   <= 1'b0;
        end else begin
            rptr_bin  <= rptr_next;
            rptr_gray <= rptr_next ^ (rptr_next >> 1);
            rdcnt     <= cnt_next;
            empty     <= (cnt_next == '0);
            aempty    <= (cnt_wide <= THRESH_U);
            underflow <= rd_en & empty;
            ptr_err   <= ptr_err | (cnt_wide > DEPTH_U);
        end
    end

    // Delay line for accepted reads, matching the RAM read latency.
    // A reset drops any pulses still in flight.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rv_pipe <= '0;
        end else begin
            rv_pipe[0] <= re_acc;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rv_pipe[i] <= rv_pipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_corefifo_rd_ctrl.sv
// Bench for corefifo_rd_ctrl (ADDRWIDTH=3, AEMPTY_THRESH=1, RD_LATENCY=1).
// A behavioural FIFO model tracks read/write positions as integers. A small RAM
// model is written by the bench's write side and read through the DUT's raddr;
// a monitor pops expected words whenever rvalid is seen.
module tb_corefifo_rd_ctrl;

    localparam int AW = 3;
    localparam int PW = AW + 1;

    // ---------------- clock / reset ----------------
    logic          rclk = 1'b0;
    logic          rrst_n = 1'b0;
    logic          rd_en = 1'b0;
    logic [PW-1:0] wptr_bin = '0;
    logic [AW-1:0] raddr;
    logic          ram_re;
    logic [PW-1:0] rptr_gray;
    logic [PW-1:0] rdcnt;
    logic          empty;
    logic          aempty;
    logic          underflow;
    logic          rvalid;
    logic          ptr_err;

    always #5 rclk = ~rclk;

    corefifo_rd_ctrl #(
        .ADDRWIDTH(AW),
        .AEMPTY_THRESH(1),
        .RD_LATENCY(1)
    ) dut (
        .rclk(rclk),
        .rrst_n(rrst_n),
        .rd_en(rd_en),
        .wptr_bin(wptr_bin),
        .raddr(raddr),
        .ram_re(ram_re),
        .rptr_gray(rptr_gray),
        .rdcnt(rdcnt),
        .empty(empty),
        .aempty(aempty),
        .underflow(underflow),
        .rvalid(rvalid),
        .ptr_err(ptr_err)
    );

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mem[8];
    logic [7:0] ram_q = '0;

    // Reference model: integer positions, modulo 16.
    int m_rptr = 0;
    int m_wptr = 0;
    int m_cnt = 0;
    bit m_empty = 1;
    bit m_aempty = 1;
    bit m_uflow = 0;
    bit m_perr = 0;
    bit m_rvalid = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // RAM with one cycle of read latency, addressed by the DUT.
    always @(posedge rclk) begin
        if (ram_re === 1'b1) ram_q <= mem[raddr];
    end

    // Monitor: every rvalid must deliver the oldest accepted word.
    always @(posedge rclk) begin
        #2;
        if (rrst_n && rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rdata_extra: rvalid with nothing expected (t=%0t)", $time);
            end else begin
                chk("rdata", {24'd0, ram_q}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic check_regs();
        chk("rdcnt", {28'd0, rdcnt}, m_cnt);
        chk("empty", {31'd0, empty}, m_empty);
        chk("aempty", {31'd0, aempty}, m_aempty);
        chk("underflow", {31'd0, underflow}, m_uflow);
        chk("rvalid", {31'd0, rvalid}, m_rvalid);
        chk("ptr_err", {31'd0, ptr_err}, m_perr);
        chk("rptr_gray", {28'd0, rptr_gray}, m_rptr ^ (m_rptr >> 1));
    endtask

    // ---------------- driver tasks ----------------
    // One read-clock cycle. The write side optionally fills RAM for the newly
    // published positions before the pointer is presented.
    task automatic step(input bit rd, input int wp, input bit wr_ram);
        bit acc;
        @(negedge rclk);
        if (wr_ram) begin
            for (int p = m_wptr; p != wp; p = (p + 1) % 16) mem[p % 8] = 8'($urandom_range(0, 255));
        end
        rd_en = rd;
        wptr_bin = PW'(wp);
        m_wptr = wp;
        acc = rd && !m_empty;
        #1;
        chk("ram_re", {31'd0, ram_re}, acc);
        chk("raddr", {29'd0, raddr}, m_rptr % 8);
        if (acc) exp_q.push_back(mem[m_rptr % 8]);
        m_uflow = rd && m_empty;
        m_rvalid = acc;
        m_rptr = (m_rptr + int'(acc)) % 16;
        m_cnt = (m_wptr - m_rptr + 16) % 16;
        m_empty = (m_cnt == 0);
        m_aempty = (m_cnt <= 1);
        if (m_cnt > 8) m_perr = 1;
        @(posedge rclk);
        #1;
        check_regs();
    endtask

    task automatic do_reset(input bit rd);
        @(negedge rclk);
        rd_en = rd;
        rrst_n = 1'b0;
        #1;
        m_rptr = 0; m_cnt = 0; m_empty = 1; m_aempty = 1;
        m_uflow = 0; m_perr = 0; m_rvalid = 0;
        exp_q.delete();
        check_regs();
        chk("rst_ram_re", {31'd0, ram_re}, 0);
        chk("rst_raddr", {29'd0, raddr}, 0);
        wptr_bin = '0;
        m_wptr = 0;
        @(negedge rclk);
        rrst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int room;
        int adv;
        do_reset(1'b0);

        // Reads on an empty FIFO: refused, underflow each cycle.
        repeat (3) step(1'b1, 0, 1'b1);

        // Publish three words, then drain them; a fourth read is refused.
        step(1'b0, 3, 1'b1);
        repeat (4) step(1'b1, 3, 1'b1);

        // Read and a write advance in the same cycle keep the count steady.
        step(1'b0, 5, 1'b1);
        step(1'b1, 6, 1'b1);
        step(1'b1, 7, 1'b1);

        // Randomized traffic, enough to wrap the pointers several times.
        for (int i = 0; i < 500; i++) begin
            room = 8 - ((m_wptr - m_rptr + 16) % 16);
            adv = $urandom_range(0, (room < 3) ? room : 3);
            step($urandom_range(0, 3) != 0, (m_wptr + adv) % 16, 1'b1);
        end
        repeat (10) step(1'b1, m_wptr, 1'b1);

        // Inconsistent write pointer raises a sticky error.
        do_reset(1'b0);
        step(1'b0, 10, 1'b0);
        step(1'b0, 2, 1'b0);
        step(1'b0, 2, 1'b0);

        // Reset while reading with four words present.
        do_reset(1'b0);
        step(1'b0, 4, 1'b1);
        step(1'b1, 4, 1'b1);
        do_reset(1'b1);
        step(1'b0, 0, 1'b1);

        // Every accepted read must have produced its data.
        repeat (3) @(posedge rclk);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
